// File: rtl/mastermind_pkg.sv
// ----------------------------------------------------------------------------
// mastermind_pkg
// Shared types and constants for the Mastermind round tracker slice.
//   - default game parameters (guess budget, pegs per code)
//   - field widths for colours, peg counts and packed guesses
//   - round-tracker state enum
//   - history entry layout {guess, red, white}
// ----------------------------------------------------------------------------
package mastermind_pkg;

    localparam int MAX_GUESSES_DEF = 8;
    localparam int PEGS_DEF        = 4;

    localparam int COLOR_W    = 3;             // one peg colour
    localparam int GUESS_W    = 12;            // four colours, slot 1 in [2:0]
    localparam int CNT_W      = 3;             // red / white peg counts
    localparam int GCOUNT_W   = 4;             // guesses scored this game
    localparam int HIST_DEPTH = 8;             // one entry per possible guess
    localparam int HIST_IDX_W = $clog2(HIST_DEPTH);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        WIN   = 2'd2,
        LOSE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [GUESS_W-1:0] guess;
        logic [CNT_W-1:0]   red;
        logic [CNT_W-1:0]   white;
    } hist_entry_t;

endpackage

// File: rtl/mastermind_round_tracker_if.sv
// ----------------------------------------------------------------------------
// mastermind_round_tracker_if
// Result channel between the peg scorer and the round tracker.
//   result_valid : one-cycle pulse, red/white/guess valid this cycle
//   red, white   : peg counts of the scored guess
//   guess        : the scored guess, four 3-bit colours
//   guess_en     : tracker -> upstream, high while a new guess may be entered
// Modports: master = scorer side, slave = tracker side.
// ----------------------------------------------------------------------------
interface mastermind_round_tracker_if;

    logic                                 result_valid;
    logic [mastermind_pkg::CNT_W-1:0]     red;
    logic [mastermind_pkg::CNT_W-1:0]     white;
    logic [mastermind_pkg::GUESS_W-1:0]   guess;
    logic                                 guess_en;

    modport master (
        output result_valid, red, white, guess,
        input  guess_en
    );

    modport slave (
        input  result_valid, red, white, guess,
        output guess_en
    );

endinterface

// File: rtl/mastermind_history.sv
// ----------------------------------------------------------------------------
// mastermind_history
// 8 x 18 register file holding one {guess, red, white} entry per round.
// Compiled only when MASTERMIND_HISTORY_EN is defined.
//   clk, resetn : clock, synchronous active-low reset
//   clear       : marks every entry empty (new game)
//   wr_en/idx/data : single write port
//   rd_idx      : read index; rd_data is registered (one-cycle latency)
// Empty entries read as zero. A write and a read of the same index in the
// same cycle return the newly written entry.
// ----------------------------------------------------------------------------
`ifdef MASTERMIND_HISTORY_EN
module mastermind_history
    import mastermind_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [HIST_IDX_W-1:0] wr_idx,
    input  hist_entry_t           wr_data,
    input  logic [HIST_IDX_W-1:0] rd_idx,
    output hist_entry_t           rd_data
);

    hist_entry_t           mem_q [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] valid_q, valid_d;
    hist_entry_t           rd_q, rd_d;

    always_comb begin
        valid_d = valid_q;
        rd_d    = '0;
        if (clear) begin
            valid_d = '0;
        end else begin
            if (wr_en) valid_d[wr_idx] = 1'b1;
            // Same-index write bypasses the array so the reader sees it now.
            if (wr_en && (wr_idx == rd_idx))
                rd_d = wr_data;
            else if (valid_q[rd_idx])
                rd_d = mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
        end
    end

    // NOTE: the storage array has no reset; the valid bits alone decide
    // whether an entry is visible, so stale contents never leak out.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_data;
    end

    assign rd_data = rd_q;

endmodule
`endif

// File: rtl/mastermind_round_tracker.sv
// ----------------------------------------------------------------------------
// mastermind_round_tracker
// Downstream of the peg scorer: counts scored guesses, decides win/loss,
// holds the last result for the displays and gates upstream guess entry.
// Optional history file (macro MASTERMIND_HISTORY_EN) lets the player page
// back through earlier rounds; without it hist_* are tied to zero.
// Ports:
//   clk, resetn   : clock, synchronous active-low reset
//   new_game      : one-cycle pulse, restarts the game from any state
//   res_if        : result channel (slave), carries guess_en back upstream
//   hist_sel      : history index to display
//   guess_count   : guesses scored this game (saturates at MAX_GUESSES)
//   win, lose     : terminal outcome flags
//   disp_red/white: last accepted result
//   hist_guess/red/white : registered history read at hist_sel
// ----------------------------------------------------------------------------
module mastermind_round_tracker
    import mastermind_pkg::*;
#(
    parameter int MAX_GUESSES = MAX_GUESSES_DEF,   // legal 1..8
    parameter int PEGS        = PEGS_DEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   new_game,
    mastermind_round_tracker_if.slave res_if,
    input  logic [HIST_IDX_W-1:0]  hist_sel,
    output logic [GCOUNT_W-1:0]    guess_count,
    output logic                   win,
    output logic                   lose,
    output logic [CNT_W-1:0]       disp_red,
    output logic [CNT_W-1:0]       disp_white,
    output logic [GUESS_W-1:0]     hist_guess,
    output logic [CNT_W-1:0]       hist_red,
    output logic [CNT_W-1:0]       hist_white
);

    state_e                state_q, state_d;
    logic [GCOUNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]      disp_red_q, disp_red_d;
    logic [CNT_W-1:0]      disp_white_q, disp_white_d;
    logic                  guess_en_q, guess_en_d;
    logic                  win_q, win_d;
    logic                  lose_q, lose_d;
    logic                  accept;

    // A result is taken only in PLAY and only if no restart is pending.
    assign accept = (state_q == PLAY) && res_if.result_valid && !new_game;

    // NOTE: every always_comb output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        disp_red_d   = disp_red_q;
        disp_white_d = disp_white_q;

        unique case (state_q)
            PLAY: begin
                if (accept) begin
                    disp_red_d   = res_if.red;
                    disp_white_d = res_if.white;
                    count_d      = count_q + GCOUNT_W'(1);
                    state_d      = CHECK;
                end
            end
            CHECK: begin
                // Win is tested first so a win on the last guess is a win.
                if (disp_red_q == CNT_W'(PEGS))
                    state_d = WIN;
                else if (count_q == GCOUNT_W'(MAX_GUESSES))
                    state_d = LOSE;
                else
                    state_d = PLAY;
            end
            WIN, LOSE: state_d = state_q;
            default:   state_d = PLAY;
        endcase

        if (new_game) begin
            state_d      = PLAY;
            count_d      = '0;
            disp_red_d   = '0;
            disp_white_d = '0;
        end

        // Outputs are registered from the next state, so they change on the
        // same edge as the state itself.
        guess_en_d = (state_d == PLAY);
        win_d      = (state_d == WIN);
        lose_d     = (state_d == LOSE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= PLAY;
            count_q      <= '0;
            disp_red_q   <= '0;
            disp_white_q <= '0;
            guess_en_q   <= 1'b1;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            disp_red_q   <= disp_red_d;
            disp_white_q <= disp_white_d;
            guess_en_q   <= guess_en_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
        end
    end

    assign res_if.guess_en = guess_en_q;
    assign guess_count     = count_q;
    assign win             = win_q;
    assign lose            = lose_q;
    assign disp_red        = disp_red_q;
    assign disp_white      = disp_white_q;

`ifdef MASTERMIND_HISTORY_EN
    hist_entry_t hist_wr_data;
    hist_entry_t hist_rd_data;

    assign hist_wr_data = '{guess: res_if.guess, red: res_if.red, white: res_if.white};

    // In PLAY count_q < MAX_GUESSES <= 8, so its low bits are the next slot.
    mastermind_history u_history (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (new_game),
        .wr_en   (accept),
        .wr_idx  (count_q[HIST_IDX_W-1:0]),
        .wr_data (hist_wr_data),
        .rd_idx  (hist_sel),
        .rd_data (hist_rd_data)
    );

    assign hist_guess = hist_rd_data.guess;
    assign hist_red   = hist_rd_data.red;
    assign hist_white = hist_rd_data.white;
`else
    // No storage: the selector and the guess word have no consumer.
    logic unused_hist_inputs;
    assign unused_hist_inputs = ^{hist_sel, res_if.guess};

    assign hist_guess = '0;
    assign hist_red   = '0;
    assign hist_white = '0;
`endif

endmodule

// File: tb/tb_mastermind_round_tracker.sv
// ----------------------------------------------------------------------------
// tb_mastermind_round_tracker
// Scoreboard bench: each stimulus cycle runs a game-level reference model and
// queues the outputs expected after the coming clock edge; an independent
// monitor pops and compares them on the following falling edge.
// Honours MASTERMIND_HISTORY_EN for the expected history read-back.
// ----------------------------------------------------------------------------
module tb_mastermind_round_tracker;

    localparam int MAX_G  = 8;
    localparam int PEGS_N = 4;

    // Game phases of the reference model.
    localparam int PH_PLAY  = 0;
    localparam int PH_CHECK = 1;
    localparam int PH_WIN   = 2;
    localparam int PH_LOSE  = 3;

    typedef struct {
        int          cyc;
        logic        ge;
        logic        win;
        logic        lose;
        logic [3:0]  cnt;
        logic [2:0]  dr;
        logic [2:0]  dw;
        logic [11:0] hg;
        logic [2:0]  hr;
        logic [2:0]  hw;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        new_game;
    logic [2:0]  hist_sel;
    logic [3:0]  guess_count;
    logic        win, lose;
    logic [2:0]  disp_red, disp_white;
    logic [11:0] hist_guess;
    logic [2:0]  hist_red, hist_white;

    mastermind_round_tracker_if bus ();

    mastermind_round_tracker dut (
        .clk         (clk),
        .resetn      (resetn),
        .new_game    (new_game),
        .res_if      (bus),
        .hist_sel    (hist_sel),
        .guess_count (guess_count),
        .win         (win),
        .lose        (lose),
        .disp_red    (disp_red),
        .disp_white  (disp_white),
        .hist_guess  (hist_guess),
        .hist_red    (hist_red),
        .hist_white  (hist_white)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t exp_q[$];

    // Reference model state.
    int          m_phase   = PH_PLAY;
    int          m_verdict = PH_PLAY;
    int          m_count   = 0;
    int          m_dr      = 0;
    int          m_dw      = 0;
    logic [17:0] m_hist [MAX_G];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, want);
        end
    endtask

    // Monitor: compare every queued expectation on the falling edge after
    // the rising edge it belongs to.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
                check("missed_sample", 32'(cyc), 32'(e.cyc));
            end else begin
                check("guess_en",    32'(bus.guess_en), 32'(e.ge));
                check("win",         32'(win),          32'(e.win));
                check("lose",        32'(lose),         32'(e.lose));
                check("guess_count", 32'(guess_count),  32'(e.cnt));
                check("disp_red",    32'(disp_red),     32'(e.dr));
                check("disp_white",  32'(disp_white),   32'(e.dw));
                check("hist_guess",  32'(hist_guess),   32'(e.hg));
                check("hist_red",    32'(hist_red),     32'(e.hr));
                check("hist_white",  32'(hist_white),   32'(e.hw));
            end
        end
    end

    // Advance the model by one clock using the inputs currently driven,
    // queue the expected outputs, then let the edge happen.
    task automatic tick();
        exp_t e;
        if (!resetn || new_game) begin
            m_phase = PH_PLAY;
            m_count = 0;
            m_dr    = 0;
            m_dw    = 0;
        end else if (m_phase == PH_PLAY) begin
            if (bus.result_valid) begin
                m_dr = int'(bus.red);
                m_dw = int'(bus.white);
                m_hist[m_count] = {bus.guess, bus.red, bus.white};
                m_count++;
                if (m_dr == PEGS_N)       m_verdict = PH_WIN;
                else if (m_count == MAX_G) m_verdict = PH_LOSE;
                else                       m_verdict = PH_PLAY;
                m_phase = PH_CHECK;
            end
        end else if (m_phase == PH_CHECK) begin
            m_phase = m_verdict;
        end

        e.cyc  = cyc + 1;
        e.ge   = (m_phase == PH_PLAY);
        e.win  = (m_phase == PH_WIN);
        e.lose = (m_phase == PH_LOSE);
        e.cnt  = 4'(m_count);
        e.dr   = 3'(m_dr);
        e.dw   = 3'(m_dw);
        {e.hg, e.hr, e.hw} = 18'd0;
`ifdef MASTERMIND_HISTORY_EN
        if (int'(hist_sel) < m_count) {e.hg, e.hr, e.hw} = m_hist[hist_sel];
`endif
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        new_game         = 1'b0;
        bus.result_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Issue one result, then two quiet cycles (3-cycle spacing).
    task automatic send(input int r, input int w, input logic [11:0] g);
        bus.result_valid = 1'b1;
        bus.red          = 3'(r);
        bus.white        = 3'(w);
        bus.guess        = g;
        tick();
        idle(2);
    endtask

    task automatic restart();
        new_game = 1'b1;
        tick();
    endtask

    initial begin
        resetn           = 1'b0;
        new_game         = 1'b0;
        hist_sel         = 3'd0;
        bus.result_valid = 1'b0;
        bus.red          = 3'd0;
        bus.white        = 3'd0;
        bus.guess        = 12'd0;

        // Reset, then idle.
        idle(3);
        resetn = 1'b1;
        idle(3);

        // Three results ending in a win; a late pulse in WIN is ignored.
        hist_sel = 3'd1;
        send(1, 2, 12'o7654);
        send(2, 1, 12'o0123);
        send(4, 0, 12'o3210);
        hist_sel = 3'd2;
        send(3, 1, 12'o1111);
        hist_sel = 3'd3;
        idle(2);

        // Eight non-winning results lose; a ninth changes nothing.
        restart();
        hist_sel = 3'd7;
        for (int i = 0; i < MAX_G; i++) send(0, 2, 12'(i * 73));
        send(0, 2, 12'o5555);
        idle(2);

        // Win on the final permitted guess.
        restart();
        for (int i = 0; i < MAX_G - 1; i++) send(1, 1, 12'(i + 1));
        send(4, 0, 12'o4444);
        idle(2);

        // new_game and result_valid together at guess_count 5: result dropped.
        restart();
        for (int i = 0; i < 5; i++) send(2, 2, 12'(i));
        new_game         = 1'b1;
        bus.result_valid = 1'b1;
        bus.red          = 3'd4;
        tick();
        idle(3);

        // History: write and read index 0 in the same cycle, then empty slot 5.
        restart();
        hist_sel = 3'd0;
        send(1, 1, 12'o1234);
        hist_sel = 3'd5;
        idle(2);

        // Result pulse that lands in CHECK is dropped.
        bus.result_valid = 1'b1; bus.red = 3'd1; bus.white = 3'd0; bus.guess = 12'o0007;
        tick();
        bus.result_valid = 1'b1; bus.red = 3'd4; bus.white = 3'd0; bus.guess = 12'o0070;
        tick();
        idle(2);

        // Reset in the middle of a game.
        send(2, 0, 12'o0707);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        idle(2);

        // Randomized play.
        for (int i = 0; i < 1500; i++) begin
            resetn           = ($urandom_range(0, 199) != 0);
            new_game         = ($urandom_range(0, 59) == 0);
            bus.result_valid = ($urandom_range(0, 2) == 0);
            bus.red          = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            bus.white        = 3'($urandom_range(0, 4));
            bus.guess        = 12'($urandom);
            hist_sel         = $urandom_range(0, 1) ? 3'(m_count) : 3'($urandom_range(0, 7));
            tick();
        end
        resetn = 1'b1;
        idle(2);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
